// File: rtl/arashi_write_arbiter.sv
// Round-robin arbiter sharing the cache write path among THREAD_NUM threads; ack same cycle, out_valid next cycle.
// One-entry output register, stalls hold everything under out_ready=0; ARASHI_WRITE_ARBITER_STATS_EN adds grant/stall counters.
module arashi_write_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]          req,
  input  logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0] req_data,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]          req_ack,
  output logic                                      out_valid,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [THREAD_NUM_WIDTH-1:0]               out_id,
  input  logic                                      out_ready
`ifdef ARASHI_WRITE_ARBITER_STATS_EN
  ,
  output logic [(16<<THREAD_NUM_WIDTH)-1:0]         grant_cnt,
  output logic [15:0]                               stall_cnt
`endif
);

  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;

  generate
    if (THREAD_NUM < 2 || THREAD_NUM > 4) begin : g_bad_thread_num
      $error("arashi_write_arbiter: THREAD_NUM must be in 2..4");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_q;
  logic [THREAD_NUM_WIDTH-1:0] ptr_q, ptr_d;
  logic                      out_valid_q;
  logic [DATA_WIDTH-1:0]     out_data_q;
  logic [THREAD_NUM_WIDTH-1:0] out_id_q;

  logic                      load;
  logic                      win_vld;
  logic [THREAD_NUM_WIDTH-1:0] win_id;
  logic [THREAD_NUM_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]     win_data;
  logic [THREAD_NUM-1:0]     ack_d;

  assign load = (state_q == IDLE) || (out_valid_q && out_ready);

  // Rotating search starting at ptr; index arithmetic wraps because THREAD_NUM is a power of two.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = 0; i < THREAD_NUM; i++) begin
      idx = ptr_q + THREAD_NUM_WIDTH'(i);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < THREAD_NUM; i++) begin
      if (THREAD_NUM_WIDTH'(i) == win_id) begin
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ptr_d = win_id + 1'b1;

  // Gated by rstn so no ack escapes while reset is held with requests pending.
  always_comb begin
    ack_d = '0;
    if (rstn && load && win_vld) begin
      ack_d[win_id] = 1'b1;
    end
  end

  assign req_ack = ack_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (load) begin
      if (win_vld) begin
        state_q     <= HOLD;
        ptr_q       <= ptr_d;
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_id_q    <= win_id;
      end else begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef ARASHI_WRITE_ARBITER_STATS_EN
  logic [(16<<THREAD_NUM_WIDTH)-1:0] grant_cnt_q;
  logic [15:0]                       stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        if (ack_d[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
        end
      end
      if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ack));
  a_ack_needs_load: assert property (@(posedge clk) disable iff (!rstn) !load |-> (req_ack == '0));

endmodule

// File: tb/tb_arashi_write_arbiter.sv
// Directed bench for arashi_write_arbiter: reset, rotation, latency, stall, wrap, async reset, optional counters.
module tb_arashi_write_arbiter;

  localparam int DW  = 32;
  localparam int TNW = 2;
  localparam int TN  = 1 << TNW;

  logic               clk;
  logic               rstn;
  logic [TN-1:0]      req;
  logic [DW*TN-1:0]   req_data;
  logic [TN-1:0]      req_ack;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [TNW-1:0]     out_id;
  logic               out_ready;
`ifdef ARASHI_WRITE_ARBITER_STATS_EN
  logic [16*TN-1:0]   grant_cnt;
  logic [15:0]        stall_cnt;
`endif

  int n_tests;
  int n_fail;

  arashi_write_arbiter #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef ARASHI_WRITE_ARBITER_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < TN; i++) req_data[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    set_data(32'hA0);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
    n_tests++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", out_id); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    rstn = 1'b1;
    #1;
    n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ack: got %b want 0001", req_ack); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hA0 || out_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_first_word: got v=%b d=%h id=%0d want v=1 d=a0 id=0", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_rotate();
    logic [TN-1:0] exp_ack;
    do_reset();
    set_data(32'hA0);
    req = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << (k % 4);
      #1;
      n_tests++; if (req_ack !== exp_ack) begin n_fail++; $display("FAIL rotate_ack[%0d]: got %b want %b", k, req_ack, exp_ack); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_data !== 32'hA0 + 32'(k % 4)) begin
        n_fail++; $display("FAIL rotate_word[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                           k, out_valid, out_id, out_data, k % 4, 32'hA0 + 32'(k % 4));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_data(32'hB0);
    req = 4'b0100;
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", req_ack); end
    @(negedge clk);
    req = 4'b0000;
    n_tests++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 32'hB2) begin
      n_fail++; $display("FAIL single_word: got v=%b id=%0d d=%h want v=1 id=2 d=b2", out_valid, out_id, out_data);
    end
    #1;
    n_tests++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL single_noack: got %b want 0000", req_ack); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || out_id !== 2'd2 || out_data !== 32'hB2) begin
      n_fail++; $display("FAIL single_drain: got v=%b id=%0d d=%h want v=0 id=2 d=b2", out_valid, out_id, out_data);
    end
    req = 4'b1111;
    #1;
    n_tests++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL single_ptr: got %b want 1000", req_ack); end
  endtask

  task automatic test_stall();
    do_reset();
    req_data = '0;
    req_data[DW-1:0] = 32'h55;
    req_data[DW +: DW] = 32'h66;
    req = 4'b0001;
    out_ready = 1'b0;
    #1;
    n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL stall_first_ack: got %b want 0001", req_ack); end
    @(negedge clk);
    req = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL stall_ack[%0d]: got %b want 0000", k, req_ack); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h55 || out_id !== 2'd0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h id=%0d want v=1 d=55 id=0", k, out_valid, out_data, out_id);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL stall_release_ack: got %b want 0010", req_ack); end
    @(negedge clk);
    n_tests++; if (out_data !== 32'h66 || out_id !== 2'd1) begin
      n_fail++; $display("FAIL stall_release_word: got d=%h id=%0d want d=66 id=1", out_data, out_id);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_data(32'hC0);
    req = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    req = 4'b1001;
    #1;
    n_tests++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_ack0: got %b want 1000", req_ack); end
    @(negedge clk);
    n_tests++; if (out_id !== 2'd3 || out_data !== 32'hC3) begin n_fail++; $display("FAIL wrap_id0: got id=%0d d=%h want id=3 d=c3", out_id, out_data); end
    #1;
    n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL wrap_ack1: got %b want 0001", req_ack); end
    @(negedge clk);
    n_tests++; if (out_id !== 2'd0 || out_data !== 32'hC0) begin n_fail++; $display("FAIL wrap_id1: got id=%0d d=%h want id=0 d=c0", out_id, out_data); end
    #1;
    n_tests++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_ack2: got %b want 1000", req_ack); end
    @(negedge clk);
    n_tests++; if (out_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id2: got %0d want 3", out_id); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    set_data(32'hD0);
    req = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    req = 4'b0000;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got %b want 1", out_valid); end
    #3;
    rstn = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || req_ack !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_drop: got v=%b ack=%b want v=0 ack=0000", out_valid, req_ack);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

`ifdef ARASHI_WRITE_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    set_data(32'hE0);
    req = 4'b0010;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    req = 4'b0000;
    out_ready = 1'b0;
    repeat (7) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (grant_cnt[16 +: 16] !== 16'd10) begin n_fail++; $display("FAIL stats_grant: got %0d want 10", grant_cnt[16 +: 16]); end
    n_tests++; if (stall_cnt !== 16'd7) begin n_fail++; $display("FAIL stats_stall: got %0d want 7", stall_cnt); end
    n_tests++; if (grant_cnt[0 +: 16] !== 16'd0) begin n_fail++; $display("FAIL stats_grant0: got %0d want 0", grant_cnt[0 +: 16]); end
    req = 4'b0010;
    repeat (70000) @(negedge clk);
    n_tests++; if (grant_cnt[16 +: 16] !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %h want ffff", grant_cnt[16 +: 16]); end
    n_tests++; if (stall_cnt !== 16'd7) begin n_fail++; $display("FAIL stats_stall_hold: got %0d want 7", stall_cnt); end
    req = 4'b0000;
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    rstn = 1'b0;
    req = '0;
    req_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_rotate();
    test_single();
    test_stall();
    test_wrap();
    test_reset_mid_hold();
`ifdef ARASHI_WRITE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
